cla8_pipe_adder: RTL and testbench

// - Pipelined WIDTH-bit carry-lookahead adder wrapping the 4-bit group carry logic.
// - Stage 1 captures operands and forms per-bit propagate/generate; stage 2 forms group carries and sums.
// - Provides valid/ready handshakes on both sides, so it sits between an operand source and a result consumer.

---
 rtl/cla8_pipe_adder.sv | 103 ++++++++++
 tb/tb_cla8_pipe_adder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cla8_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder built from 4-bit lookahead groups.
// Stage 1 registers per-bit propagate/generate; stage 2 registers sum, carry-out and overflow.
module cla8_pipe_adder #(
    parameter int WIDTH = 8,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_co,
    output logic             out_ovf
);

    localparam int NGRP = WIDTH / GROUP;

    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_g;
    logic             s1_ci;
    logic             s1_valid;

    logic [WIDTH-1:0] carry_in_bit;
    logic             carry_out;
    logic [WIDTH-1:0] sum_c;
    logic             ovf_c;
    logic             adv2;
    logic             accept;

    // Two-level lookahead for one group; returns {c4, c3, c2, c1, c0}.
    function automatic logic [4:0] grp_carry(input logic [3:0] p, input logic [3:0] g,
                                             input logic ci);
        logic [4:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    always_comb begin
        logic       c_run;
        logic [4:0] gc;
        carry_in_bit = '0;
        c_run        = s1_ci;
        gc           = '0;
        for (int k = 0; k < NGRP; k++) begin
            gc = grp_carry(s1_p[k*GROUP +: GROUP], s1_g[k*GROUP +: GROUP], c_run);
            carry_in_bit[k*GROUP +: GROUP] = gc[3:0];
            c_run = gc[4];
        end
        carry_out = c_run;
    end

    assign sum_c = s1_p ^ carry_in_bit;
    assign ovf_c = carry_in_bit[WIDTH-1] ^ carry_out;

    // A beat moves on valid && ready at the rising edge; in_ready depends
    // combinationally on out_ready because there is no skid buffer.
    assign adv2     = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || adv2;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_p      <= '0;
            s1_g      <= '0;
            s1_ci     <= 1'b0;
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_co    <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            if (accept) begin
                s1_p     <= in_a ^ in_b;
                s1_g     <= in_a & in_b;
                s1_ci    <= in_ci;
                s1_valid <= 1'b1;
            end else if (adv2) begin
                s1_valid <= 1'b0;
            end

            // Data outputs keep their last value when the result is drained.
            if (adv2) begin
                out_sum   <= sum_c;
                out_co    <= carry_out;
                out_ovf   <= ovf_c;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cla8_pipe_adder.sv
// Self-checking bench for cla8_pipe_adder: directed vectors, backpressure, reset, random stream.
module tb_cla8_pipe_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_ci;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_co;
    logic         out_ovf;

    int n_checks = 0;
    int n_errors = 0;

    logic [W+1:0] exp_q[$];

    cla8_pipe_adder #(.WIDTH(W), .GROUP(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_ci(in_ci),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_co(out_co), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_ci    = ci;
    endtask

    // One beat through an otherwise empty pipe with out_ready held high.
    task automatic send_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ci, input logic [W-1:0] es, input logic eco,
                            input logic eovf);
        @(negedge clk);
        out_ready = 1'b1;
        drive(1'b1, a, b, ci);
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0);
        check({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_res"}, {22'd0, out_co, out_ovf, out_sum}, {22'd0, eco, eovf, es});
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sum", {24'd0, out_sum}, 32'd0);
        check("rst_out_co", {31'd0, out_co}, 32'd0);
        check("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        send_one("b0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        send_one("bff_00c", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        send_one("b7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        send_one("b80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

        // Streaming: beat k driven at negedge k, visible at negedge k+2.
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0);
        @(negedge clk);
        out_ready = 1'b1;
        for (int n = 0; n < 7; n++) begin
            if (n > 0) @(negedge clk);
            check($sformatf("strm_valid%0d", n), {31'd0, out_valid},
                  (n >= 2 && n <= 5) ? 32'd1 : 32'd0);
            if (n >= 2 && n <= 5)
                check($sformatf("strm_sum%0d", n), {24'd0, out_sum}, 2 * (n - 1));
            if (n < 4) begin
                drive(1'b1, W'(n + 1), W'(n + 1), 1'b0);
                #1;
                check($sformatf("strm_rdy%0d", n), {31'd0, in_ready}, 32'd1);
            end else begin
                drive(1'b0, '0, '0, 1'b0);
            end
        end

        // Backpressure: A=10+1, B=20+2, C=30+3 with the consumer stalled.
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 8'd10, 8'd1, 1'b0);
        @(negedge clk);
        drive(1'b1, 8'd20, 8'd2, 1'b0);
        #1;
        check("bp_rdy_after1", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        drive(1'b1, 8'd30, 8'd3, 1'b0);
        #1;
        check("bp_rdy_after2", {31'd0, in_ready}, 32'd0);
        check("bp_sum_m2", {24'd0, out_sum}, 32'd11);
        @(negedge clk);
        check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        check("bp_hold_sum", {24'd0, out_sum}, 32'd11);
        check("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        #1;
        check("bp_rel_rdy", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0);
        check("bp_sum_b", {23'd0, out_valid, out_sum}, {23'd0, 1'b1, 8'd22});
        @(negedge clk);
        check("bp_sum_c", {23'd0, out_valid, out_sum}, {23'd0, 1'b1, 8'd33});
        @(negedge clk);
        check("bp_drained", {31'd0, out_valid}, 32'd0);

        // Reset with two beats in flight.
        drive(1'b1, 8'd5, 8'd6, 1'b0);
        @(negedge clk);
        drive(1'b1, 8'd7, 8'd8, 1'b0);
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mrst_valid", {31'd0, out_valid}, 32'd0);
        check("mrst_rdy", {31'd0, in_ready}, 32'd1);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check($sformatf("mrst_stale%0d", n), {31'd0, out_valid}, 32'd0);
        end

        // Random stream against a scoreboard of a+b+ci.
        begin
            int pushed = 0;
            int cycles = 0;
            logic [W-1:0] a, b;
            logic         ci;
            logic [W:0]   full;
            logic         ovf;
            logic [W+1:0] exp_v;
            while ((pushed < 10000 || exp_q.size() != 0) && cycles < 60000) begin
                @(negedge clk);
                cycles++;
                a  = W'($urandom_range(0, 255));
                b  = W'($urandom_range(0, 255));
                ci = 1'($urandom_range(0, 1));
                drive((pushed < 10000) && ($urandom_range(0, 3) != 0), a, b, ci);
                out_ready = ($urandom_range(0, 3) != 0);
                #1;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("rnd_unexpected", {31'd0, out_valid}, 32'd0);
                    end else begin
                        exp_v = exp_q.pop_front();
                        check("rnd_res", {22'd0, out_co, out_ovf, out_sum}, {22'd0, exp_v});
                    end
                end
                if (in_valid && in_ready) begin
                    full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
                    ovf   = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
                    exp_q.push_back({full[W], ovf, full[W-1:0]});
                    pushed++;
                end
            end
            drive(1'b0, '0, '0, 1'b0);
            check("rnd_beats", pushed, 10000);
            check("rnd_q_empty", exp_q.size(), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
